// File: rtl/rec_stream_ctrl.sv
// Recording stream scheduler: accepts ADC sample pairs into a one-entry buffer and
// serializes each pair MSB-first on two data lines, framed by the adc_en strobe.
module rec_stream_ctrl #(
   parameter int DATA_W    = 10,
   parameter int FRAME_GAP = 2
) (
   input  logic              clk_ref_i,
   input  logic              resetn_i,
   input  logic              enable_i,
   input  logic [DATA_W-1:0] sample1_i,
   input  logic [DATA_W-1:0] sample2_i,
   input  logic              sample_valid_i,
   output logic              sample_ready_o,
   output logic              adc_en_o,
   output logic              rec_data1_o,
   output logic              rec_data2_o,
   output logic              busy_o,
   output logic              overrun_o,
   input  logic              overrun_clr_i
);

   localparam int BCW = $clog2(DATA_W);
   localparam int GCW = 4;
   localparam logic [BCW-1:0] BIT_LAST = BCW'(DATA_W - 1);
   localparam logic [GCW-1:0] GAP_LAST = (FRAME_GAP > 0) ? GCW'(FRAME_GAP - 1) : {GCW{1'b0}};
   localparam logic           GAP_EN   = (FRAME_GAP > 0);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_GAP   = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [BCW-1:0]    bit_cnt_q, bit_cnt_d;
   logic [GCW-1:0]    gap_cnt_q, gap_cnt_d;
   logic [DATA_W-1:0] sh1_q, sh1_d, sh2_q, sh2_d;
   logic [DATA_W-1:0] buf1_q, buf1_d, buf2_q, buf2_d;
   logic              buf_full_q, buf_full_d;
   logic              ready_q, ready_d;
   logic              overrun_q, overrun_d;
   logic              adc_en_q, adc_en_d;
   logic              data1_q, data1_d, data2_q, data2_d;
   logic              busy_q, busy_d;
   logic              accept_s, overrun_set_s, load_cycle_s, load_s;

   // Cycles in which a buffered pair may be moved into the shift registers.
   always_comb begin
      load_cycle_s = 1'b0;
      case (state_q)
         ST_IDLE:  load_cycle_s = 1'b1;
         ST_SHIFT: load_cycle_s = (bit_cnt_q == {BCW{1'b0}}) && !GAP_EN;
         ST_GAP:   load_cycle_s = (gap_cnt_q == {GCW{1'b0}});
         default:  load_cycle_s = 1'b0;
      endcase
   end

   // Holding buffer, handshake and sticky overrun; a new overrun beats a clear.
   always_comb begin
      accept_s      = sample_valid_i & ready_q;
      overrun_set_s = sample_valid_i & ~ready_q;
      load_s        = load_cycle_s & enable_i & buf_full_q;
      buf1_d        = buf1_q;
      buf2_d        = buf2_q;
      buf_full_d    = buf_full_q;
      overrun_d     = overrun_q;
      if (accept_s) begin
         buf1_d     = sample1_i;
         buf2_d     = sample2_i;
         buf_full_d = 1'b1;
      end else if (load_s) begin
         buf_full_d = 1'b0;
      end else begin
         buf_full_d = buf_full_q;
      end
      if (overrun_set_s) begin
         overrun_d = 1'b1;
      end else if (overrun_clr_i) begin
         overrun_d = 1'b0;
      end else begin
         overrun_d = overrun_q;
      end
      ready_d = ~buf_full_d;
   end

   // Serializer FSM: a load always wins and restarts a frame from the MSB.
   always_comb begin
      state_d   = state_q;
      bit_cnt_d = bit_cnt_q;
      gap_cnt_d = gap_cnt_q;
      sh1_d     = sh1_q;
      sh2_d     = sh2_q;
      if (load_s) begin
         state_d   = ST_SHIFT;
         bit_cnt_d = BIT_LAST;
         sh1_d     = buf1_q;
         sh2_d     = buf2_q;
      end else begin
         case (state_q)
            ST_IDLE: state_d = ST_IDLE;
            ST_SHIFT: begin
               sh1_d = {sh1_q[DATA_W-2:0], 1'b0};
               sh2_d = {sh2_q[DATA_W-2:0], 1'b0};
               if (bit_cnt_q != {BCW{1'b0}}) begin
                  bit_cnt_d = bit_cnt_q - BCW'(1);
               end else if (GAP_EN) begin
                  state_d   = ST_GAP;
                  gap_cnt_d = GAP_LAST;
               end else begin
                  state_d = ST_IDLE;
               end
            end
            ST_GAP: begin
               if (gap_cnt_q != {GCW{1'b0}}) begin
                  gap_cnt_d = gap_cnt_q - GCW'(1);
               end else begin
                  state_d = ST_IDLE;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   // Output registers take the values of the state being entered.
   always_comb begin
      busy_d   = (state_d != ST_IDLE);
      adc_en_d = (state_d == ST_SHIFT);
      data1_d  = adc_en_d & sh1_d[DATA_W-1];
      data2_d  = adc_en_d & sh2_d[DATA_W-1];
   end

   // State and output registers; reset aborts any frame and drops the buffer.
   always_ff @(posedge clk_ref_i or negedge resetn_i) begin
      if (!resetn_i) begin
         state_q    <= ST_IDLE;
         bit_cnt_q  <= {BCW{1'b0}};
         gap_cnt_q  <= {GCW{1'b0}};
         sh1_q      <= {DATA_W{1'b0}};
         sh2_q      <= {DATA_W{1'b0}};
         buf1_q     <= {DATA_W{1'b0}};
         buf2_q     <= {DATA_W{1'b0}};
         buf_full_q <= 1'b0;
         ready_q    <= 1'b1;
         overrun_q  <= 1'b0;
         adc_en_q   <= 1'b0;
         data1_q    <= 1'b0;
         data2_q    <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         bit_cnt_q  <= bit_cnt_d;
         gap_cnt_q  <= gap_cnt_d;
         sh1_q      <= sh1_d;
         sh2_q      <= sh2_d;
         buf1_q     <= buf1_d;
         buf2_q     <= buf2_d;
         buf_full_q <= buf_full_d;
         ready_q    <= ready_d;
         overrun_q  <= overrun_d;
         adc_en_q   <= adc_en_d;
         data1_q    <= data1_d;
         data2_q    <= data2_d;
         busy_q     <= busy_d;
      end
   end

   assign sample_ready_o = ready_q;
   assign adc_en_o       = adc_en_q;
   assign rec_data1_o    = data1_q;
   assign rec_data2_o    = data2_q;
   assign busy_o         = busy_q;
   assign overrun_o      = overrun_q;

endmodule
